// File: rtl/gear_ctrl_pkg.sv
// Shared definitions for the gearbox rate-conversion sequencer.
package gear_ctrl_pkg;

  // FSM state encodings; 3'd5..3'd7 are illegal and recover to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILL      = 3'd2,
    ST_READY     = 3'd3,
    ST_HOLDOFF   = 3'd4
  } gear_state_e;

  localparam int RELOCK_CNT_W = 8;

  // Largest of three cycle parameters, used to size the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gear_rate_ctrl_sync2.sv
// Single-bit two-flop synchronizer, resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops to settle metastability on an asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gear_rate_ctrl.sv
// Sequencer that enables the Rx/Tx gearboxes after a qualified lock period,
// waits for the gearbox pipeline to fill, tears down on lock loss and
// enforces a hold-off before re-arming. Counts lock-loss teardowns from READY.
//
// Handshake: there is no valid/ready pair here; enable_req is a level
// request sampled every clk_125 edge, and drate_enable/gear_ready are
// levels that stay asserted only while the request and qualified lock hold.
module gear_rate_ctrl
  import gear_ctrl_pkg::*;
#(
  parameter int LOCK_CYCLES    = 1024,
  parameter int FILL_CYCLES    = 8,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                    clk_125,
  input  logic                    rst_n,
  input  logic                    enable_req,
  input  logic                    pll_lock,
  input  logic                    cdr_lock,
  input  logic                    rx_los,
  input  logic                    cnt_clr,
  output logic                    drate_enable,
  output logic                    gear_ready,
  output logic [2:0]              state,
  output logic [RELOCK_CNT_W-1:0] relock_cnt
);

  localparam int CNT_W = $clog2(max3(LOCK_CYCLES, FILL_CYCLES, HOLDOFF_CYCLES));
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic pll_lock_s;
  logic cdr_lock_s;
  logic rx_los_s;
  logic lock_ok;
  logic teardown;

  gear_state_e             state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    drate_en_q;
  logic                    gear_rdy_q;
  logic [RELOCK_CNT_W-1:0] relock_q;
  logic [RELOCK_CNT_W-1:0] relock_d;

  sync2 u_sync_pll (.clk(clk_125), .rst_n(rst_n), .d_i(pll_lock), .q_o(pll_lock_s));
  sync2 u_sync_cdr (.clk(clk_125), .rst_n(rst_n), .d_i(cdr_lock), .q_o(cdr_lock_s));
  sync2 u_sync_los (.clk(clk_125), .rst_n(rst_n), .d_i(rx_los),   .q_o(rx_los_s));

  assign lock_ok  = pll_lock_s & cdr_lock_s & ~rx_los_s;
  assign teardown = ~lock_ok | ~enable_req;

  // Sequencing FSM with shared counter; outputs registered alongside state.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      drate_en_q <= 1'b0;
      gear_rdy_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable_req) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (!enable_req) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (!lock_ok) begin
            cnt_q <= '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_q    <= ST_FILL;
            cnt_q      <= '0;
            drate_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_FILL: begin
          // Teardown takes precedence over fill completion.
          if (teardown) begin
            state_q    <= ST_HOLDOFF;
            cnt_q      <= '0;
            drate_en_q <= 1'b0;
            gear_rdy_q <= 1'b0;
          end else if (cnt_q == FILL_LAST) begin
            state_q    <= ST_READY;
            cnt_q      <= '0;
            gear_rdy_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_READY: begin
          if (teardown) begin
            state_q    <= ST_HOLDOFF;
            cnt_q      <= '0;
            drate_en_q <= 1'b0;
            gear_rdy_q <= 1'b0;
          end
        end
        ST_HOLDOFF: begin
          if (cnt_q == HOLD_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          drate_en_q <= 1'b0;
          gear_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  // Next relock count: clear wins, otherwise saturating bump on lock loss in READY.
  always_comb begin
    relock_d = relock_q;
    if (cnt_clr) begin
      relock_d = '0;
    end else if ((state_q == ST_READY) && !lock_ok && (relock_q != '1)) begin
      relock_d = relock_q + RELOCK_CNT_W'(1);
    end
  end

  // Relock status register.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      relock_q <= '0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign drate_enable = drate_en_q;
  assign gear_ready   = gear_rdy_q;
  assign state        = state_q;
  assign relock_cnt   = relock_q;

endmodule

// File: tb/tb_gear_rate_ctrl.sv
// Directed bench for gear_rate_ctrl with LOCK=16, FILL=8, HOLDOFF=16.
module tb_gear_rate_ctrl;

  logic       clk_125;
  logic       rst_n;
  logic       enable_req;
  logic       pll_lock;
  logic       cdr_lock;
  logic       rx_los;
  logic       cnt_clr;
  logic       drate_enable;
  logic       gear_ready;
  logic [2:0] state;
  logic [7:0] relock_cnt;

  int checks;
  int errors;
  int exp_rc;

  typedef struct {
    logic       en;
    logic       pll;
    logic       cdr;
    logic       los;
    int         n;
    logic       exp_de;
    logic       exp_gr;
    logic [2:0] exp_st;
    logic [7:0] exp_rc;
  } vec_t;

  vec_t vecs[14];

  gear_rate_ctrl #(
    .LOCK_CYCLES   (16),
    .FILL_CYCLES   (8),
    .HOLDOFF_CYCLES(16)
  ) dut (
    .clk_125     (clk_125),
    .rst_n       (rst_n),
    .enable_req  (enable_req),
    .pll_lock    (pll_lock),
    .cdr_lock    (cdr_lock),
    .rx_los      (rx_los),
    .cnt_clr     (cnt_clr),
    .drate_enable(drate_enable),
    .gear_ready  (gear_ready),
    .state       (state),
    .relock_cnt  (relock_cnt)
  );

  // Clock.
  initial clk_125 = 1'b0;
  always #4 clk_125 = ~clk_125;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic de, input logic gr,
                          input logic [2:0] st, input logic [7:0] rc);
    chk({tag, ".drate_enable"}, int'(drate_enable), int'(de));
    chk({tag, ".gear_ready"},   int'(gear_ready),   int'(gr));
    chk({tag, ".state"},        int'(state),        int'(st));
    chk({tag, ".relock_cnt"},   int'(relock_cnt),   int'(rc));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_125);
  endtask

  // Bounded poll for a state, sampled on the falling edge.
  task automatic wait_state(input logic [2:0] target, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (state == target) break;
      @(negedge clk_125);
    end
    if (state != target) begin
      checks++;
      errors++;
      $display("FAIL wait_state: got %0d expected %0d within %0d cycles", state, target, budget);
    end
  endtask

  function automatic vec_t mkv(input logic en, input logic los, input int n,
                               input logic de, input logic gr, input logic [2:0] st,
                               input logic [7:0] rc);
    vec_t v;
    v.en = en; v.pll = 1'b1; v.cdr = 1'b1; v.los = los; v.n = n;
    v.exp_de = de; v.exp_gr = gr; v.exp_st = st; v.exp_rc = rc;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    exp_rc = 0;

    // Lock-up, rx_los teardown, hold-off and automatic re-lock.
    vecs[0]  = mkv(1'b0, 1'b0, 4,  1'b0, 1'b0, 3'd0, 8'd0);
    vecs[1]  = mkv(1'b1, 1'b0, 1,  1'b0, 1'b0, 3'd1, 8'd0);
    vecs[2]  = mkv(1'b1, 1'b0, 15, 1'b0, 1'b0, 3'd1, 8'd0);
    vecs[3]  = mkv(1'b1, 1'b0, 1,  1'b1, 1'b0, 3'd2, 8'd0);
    vecs[4]  = mkv(1'b1, 1'b0, 7,  1'b1, 1'b0, 3'd2, 8'd0);
    vecs[5]  = mkv(1'b1, 1'b0, 1,  1'b1, 1'b1, 3'd3, 8'd0);
    vecs[6]  = mkv(1'b1, 1'b1, 2,  1'b1, 1'b1, 3'd3, 8'd0);
    vecs[7]  = mkv(1'b1, 1'b1, 1,  1'b0, 1'b0, 3'd4, 8'd1);
    vecs[8]  = mkv(1'b1, 1'b0, 15, 1'b0, 1'b0, 3'd4, 8'd1);
    vecs[9]  = mkv(1'b1, 1'b0, 1,  1'b0, 1'b0, 3'd0, 8'd1);
    vecs[10] = mkv(1'b1, 1'b0, 1,  1'b0, 1'b0, 3'd1, 8'd1);
    vecs[11] = mkv(1'b1, 1'b0, 15, 1'b0, 1'b0, 3'd1, 8'd1);
    vecs[12] = mkv(1'b1, 1'b0, 1,  1'b1, 1'b0, 3'd2, 8'd1);
    vecs[13] = mkv(1'b1, 1'b0, 8,  1'b1, 1'b1, 3'd3, 8'd1);

    // Reset with locks already good at the pins.
    rst_n = 1'b0; enable_req = 1'b0; pll_lock = 1'b1; cdr_lock = 1'b1;
    rx_los = 1'b0; cnt_clr = 1'b0;
    cycles(3);
    chk_outs("reset", 1'b0, 1'b0, 3'd0, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      enable_req = vecs[i].en;
      pll_lock   = vecs[i].pll;
      cdr_lock   = vecs[i].cdr;
      rx_los     = vecs[i].los;
      cycles(vecs[i].n);
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_de, vecs[i].exp_gr,
               vecs[i].exp_st, vecs[i].exp_rc);
    end
    exp_rc = 1;

    // enable_req drop from READY: teardown without counting a relock.
    enable_req = 1'b0;
    cycles(1);
    chk_outs("req_drop_ready", 1'b0, 1'b0, 3'd4, 8'(exp_rc));
    cycles(16);
    chk("req_drop_idle.state", int'(state), 0);
    enable_req = 1'b1;
    cycles(1);
    chk("glitch_wait.state", int'(state), 1);
    // cdr_lock glitch at the pin once cnt has reached 10.
    cycles(10);
    cdr_lock = 1'b0;
    cycles(1);
    cdr_lock = 1'b1;
    cycles(17);
    chk("glitch_restart.state", int'(state), 1);
    chk("glitch_restart.drate_enable", int'(drate_enable), 0);
    cycles(1);
    chk("glitch_fill.state", int'(state), 2);
    chk("glitch_fill.drate_enable", int'(drate_enable), 1);
    // enable_req drops in FILL at cnt=7: teardown wins over completion.
    cycles(7);
    chk("fill_cnt7.gear_ready", int'(gear_ready), 0);
    enable_req = 1'b0;
    cycles(1);
    chk_outs("fill_abort", 1'b0, 1'b0, 3'd4, 8'(exp_rc));

    // pll_lock loss latency from READY: outputs fall on the third edge.
    enable_req = 1'b1;
    wait_state(3'd3, 200);
    pll_lock = 1'b0;
    cycles(1);
    chk_outs("pll_loss_e1", 1'b1, 1'b1, 3'd3, 8'(exp_rc));
    cycles(1);
    chk_outs("pll_loss_e2", 1'b1, 1'b1, 3'd3, 8'(exp_rc));
    cycles(1);
    exp_rc = exp_rc + 1;
    chk_outs("pll_loss_e3", 1'b0, 1'b0, 3'd4, 8'(exp_rc));
    pll_lock = 1'b1;

    // Many forced losses to drive the counter into saturation.
    for (int i = 0; i < 260; i++) begin
      wait_state(3'd3, 200);
      rx_los = 1'b1;
      cycles(3);
      rx_los = 1'b0;
      if (exp_rc < 255) exp_rc = exp_rc + 1;
    end
    chk("saturate.relock_cnt", int'(relock_cnt), exp_rc);
    chk("saturate.state", int'(state), 4);

    // cnt_clr on the same edge as a loss event.
    wait_state(3'd3, 200);
    rx_los = 1'b1;
    cycles(2);
    cnt_clr = 1'b1;
    cycles(1);
    cnt_clr = 1'b0;
    rx_los  = 1'b0;
    exp_rc  = 0;
    chk_outs("clr_vs_loss", 1'b0, 1'b0, 3'd4, 8'(exp_rc));
    cycles(1);
    chk("clr_hold.relock_cnt", int'(relock_cnt), exp_rc);
    wait_state(3'd3, 200);
    rx_los = 1'b1;
    cycles(3);
    rx_los = 1'b0;
    exp_rc = 1;
    chk("count_after_clr.relock_cnt", int'(relock_cnt), exp_rc);

    // Asynchronous reset while READY: outputs drop before any clock edge.
    wait_state(3'd3, 200);
    chk("pre_reset.gear_ready", int'(gear_ready), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async_reset", 1'b0, 1'b0, 3'd0, 8'd0);
    @(negedge clk_125);
    rst_n = 1'b1;
    enable_req = 1'b0;
    cycles(2);
    chk_outs("post_reset", 1'b0, 1'b0, 3'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gear_rate_ctrl.md
# gear_rate_ctrl

Sequencing controller for the Rx/Tx rate-conversion gearboxes in the 125 MHz domain. It generates `drate_enable` for the gearboxes only after the SERDES PLL and CDR have been stably locked, with no loss-of-signal, for a programmable time. It then waits for the gearbox pipeline to fill before declaring the link datapath ready. On lock loss it tears the gearbox down and enforces a hold-off before re-arming. It also counts re-lock events for status registers.

## Interface
Parameters:
- `LOCK_CYCLES`, default 1024: consecutive qualified-lock cycles required before enabling the gearbox; minimum 2.
- `FILL_CYCLES`, default 8: cycles from `drate_enable` rise to `gear_ready`; minimum 6, to cover the gearbox 4-clock read hold-off plus synchronizer.
- `HOLDOFF_CYCLES`, default 16: minimum time `drate_enable` stays low after teardown; minimum 2.

Ports:
- `clk_125`, in, 1: 125 MHz clock. The only clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `enable_req`, in, 1: software/LTSSM request to run the datapath; synchronous to `clk_125`.
- `pll_lock`, in, 1: SERDES PLL lock; asynchronous, synchronized internally.
- `cdr_lock`, in, 1: Rx CDR lock; asynchronous, synchronized internally.
- `rx_los`, in, 1: Rx loss of signal, active high; asynchronous, synchronized internally.
- `cnt_clr`, in, 1: synchronous clear of `relock_cnt`.
- `drate_enable`, out, 1: enable to the Rx/Tx gearboxes.
- `gear_ready`, out, 1: gearbox output data is valid.
- `state`, out, 3: current FSM state encoding.
- `relock_cnt`, out, 8: saturating count of READY-to-HOLDOFF transitions caused by loss of qualified lock.

## Operation
- The three asynchronous inputs each pass through a 2-flop synchronizer.
- `lock_ok = pll_lock_s & cdr_lock_s & ~rx_los_s`.
- One shared counter `cnt`, sized `$clog2` of the largest parameter. It is cleared on every state transition.
- FSM states:
  - IDLE (3'd0): outputs low. `enable_req=1` -> WAIT_LOCK.
  - WAIT_LOCK (3'd1):
    - `enable_req=0` -> IDLE.
    - `lock_ok=0` -> `cnt` := 0.
    - Otherwise `cnt` increments; when `lock_ok` holds with `cnt==LOCK_CYCLES-1` -> FILL.
  - FILL (3'd2): `drate_enable=1`, `cnt` increments; at `cnt==FILL_CYCLES-1` -> READY.
  - READY (3'd3): `drate_enable=1`, `gear_ready=1`.
  - HOLDOFF (3'd4): outputs low, `cnt` increments; at `cnt==HOLDOFF_CYCLES-1` -> IDLE.
- Teardown: in FILL or READY, `lock_ok=0` or `enable_req=0` -> HOLDOFF.
- Priority:
  - Teardown beats count completion in FILL.
  - `enable_req=0` beats lock completion in WAIT_LOCK.
- `relock_cnt`:
  - Increments on a READY -> HOLDOFF transition with `lock_ok=0`, even if `enable_req` also dropped.
  - Saturates at 255.
  - `cnt_clr` wins over a simultaneous increment.
- Encodings 5-7 are illegal; they recover to IDLE on the next edge.
- Reset values: `drate_enable=0`, `gear_ready=0`, `state=3'd0`, `relock_cnt=0`, synchronizers 0 (so `lock_ok=0`).
- `rst_n` asserted mid-operation drops all outputs immediately (asynchronously).

## Timing
- All outputs are registered directly from state/counter flops, with no combinational path from inputs.
- Input to `lock_ok` latency: 2 cycles.
- Lock-up sequence:
  - `lock_ok` first high at edge N (counted at N, `cnt`=0) puts the FSM in FILL after edge N+LOCK_CYCLES-1; `drate_enable` is high from that edge.
  - `gear_ready` rises exactly FILL_CYCLES edges after `drate_enable` rises.
- Lock loss:
  - A fall of `pll_lock` at the pin reaches `lock_ok` after 2 edges.
  - `drate_enable` and `gear_ready` fall on the following edge, 3 edges worst case after the pin.
- `drate_enable` low time after teardown is at least `HOLDOFF_CYCLES` + 1 (IDLE) + `LOCK_CYCLES` cycles.
- `enable_req` held high continuously gives automatic re-lock with no software action.

## Structure
- Shared package `gear_ctrl_pkg`: 3-bit state typedef/constants (IDLE..HOLDOFF) and the `RELOCK_CNT_W=8` constant. Status decode logic reuses these.
- Sub-module `sync2`: a single-bit 2-flop synchronizer with async active-low reset to 0, instantiated three times.
- FSM, counter and `relock_cnt` live in the top module.

## Test plan
- Reset, then `enable_req=1` with all locks good and `LOCK_CYCLES=16`, `FILL_CYCLES=8` -> `drate_enable` rises 16 cycles after `lock_ok`; `gear_ready` rises 8 cycles later; state reads 1 -> 2 -> 3.
- `cdr_lock` glitches low for 1 cycle at `cnt`=10 in WAIT_LOCK -> `cnt` restarts; FILL is entered 16 qualified cycles after the glitch clears.
- In READY, `rx_los` rises -> outputs fall 3 edges later; HOLDOFF lasts 16 cycles; `relock_cnt`=1; automatic re-lock reaches READY again.
- In FILL at `cnt`=7, `enable_req` drops -> HOLDOFF, not READY; `gear_ready` never asserts; `relock_cnt` unchanged.
- 260 forced lock losses -> `relock_cnt` saturates at 255; `cnt_clr` concurrent with a loss event -> 0.
- `rst_n` pulsed low while in READY -> `drate_enable`, `gear_ready` and `state` go to 0 asynchronously, before the next clock edge.
